// File: rtl/stage_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stage_sequencer_pkg
//  Description : Shared stage encoding and widths for the stage sequencer and
//                the register-file control that decodes its stage output.
//  Contents    : STAGE_W, INSTR_W, PC_W, WAIT_W, stage_e, is_mem_stage()
//  Revision    : 1.0  initial release
// ============================================================================
package stage_sequencer_pkg;

    localparam int STAGE_W = 3;
    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int WAIT_W  = 8;

    typedef enum logic [STAGE_W-1:0] {
        STAGE_FETCH           = 3'd0,
        STAGE_MEMORY_READ     = 3'd1,
        STAGE_REGISTER_UPDATE = 3'd2,
        STAGE_MEMORY_WRITE    = 3'd3,
        STAGE_PC_UPDATE       = 3'd4,
        STAGE_IDLE            = 3'd5,
        STAGE_HALTED          = 3'd6
    } stage_e;

    // Stages that hold a memory request open until mem_ready or timeout.
    function automatic logic is_mem_stage(input stage_e s);
        return (s == STAGE_FETCH) || (s == STAGE_MEMORY_READ) ||
               (s == STAGE_MEMORY_WRITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : stage_sequencer
//  Description : Multi-cycle instruction stage sequencer:
//                FETCH -> MEMORY_READ -> REGISTER_UPDATE -> MEMORY_WRITE
//                -> PC_UPDATE, with IDLE/HALTED parking states, a per-stage
//                memory wait timeout and a sticky bus_error flag.
//  Ports       : clk, rst (async, active-high)
//                run, halt_req       - start/resume, stop after instruction
//                mem_ready, instr_in - memory handshake and fetched word
//                pc_load, pc_target  - branch target taken in PC_UPDATE
//                stage               - registered stage code
//                mem_req, mem_we     - memory request / write qualifier
//                pc, instr, retired  - architectural state
//                bus_error           - sticky memory-timeout flag
//  Revision    : 1.0  initial release
// ============================================================================
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC    = 32'h0,
    parameter int unsigned     MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               halt_req,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               pc_load,
    input  logic [PC_W-1:0]    pc_target,
    output logic [STAGE_W-1:0] stage,
    output logic               mem_req,
    output logic               mem_we,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        retired,
    output logic               bus_error
);

    // Last wait count before the stage is declared timed out.
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(MEM_TIMEOUT - 1);

    stage_e             r_stage;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [31:0]        r_retired;
    logic               r_bus_error;
    logic               r_halt_pending;
    logic [WAIT_W-1:0]  r_wait_cnt;

    stage_e             w_stage_nxt;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic [31:0]        w_retired_nxt;
    logic               w_bus_error_nxt;
    logic               w_halt_pending_nxt;
    logic [WAIT_W-1:0]  w_wait_cnt_nxt;
    logic               w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage        <= STAGE_IDLE;
            r_pc           <= RESET_PC;
            r_instr        <= '0;
            r_retired      <= '0;
            r_bus_error    <= 1'b0;
            r_halt_pending <= 1'b0;
            r_wait_cnt     <= '0;
        end else begin
            r_stage        <= w_stage_nxt;
            r_pc           <= w_pc_nxt;
            r_instr        <= w_instr_nxt;
            r_retired      <= w_retired_nxt;
            r_bus_error    <= w_bus_error_nxt;
            r_halt_pending <= w_halt_pending_nxt;
            r_wait_cnt     <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_stage_nxt        = r_stage;
        w_pc_nxt           = r_pc;
        w_instr_nxt        = r_instr;
        w_retired_nxt      = r_retired;
        w_bus_error_nxt    = r_bus_error;
        w_halt_pending_nxt = r_halt_pending;
        w_wait_cnt_nxt     = '0;
        w_timeout          = 1'b0;

        // The counter only runs while a memory stage is stalled; completion,
        // timeout and every non-memory stage leave it at zero, so each memory
        // stage is entered with a fresh count.
        if (is_mem_stage(r_stage) && !mem_ready) begin
            if (r_wait_cnt == c_wait_last) begin
                w_timeout = 1'b1;
            end else begin
                w_wait_cnt_nxt = r_wait_cnt + 8'd1;
            end
        end

        if (halt_req && (is_mem_stage(r_stage) ||
                         (r_stage == STAGE_REGISTER_UPDATE))) begin
            w_halt_pending_nxt = 1'b1;
        end

        case (r_stage)
            STAGE_IDLE: begin
                if (run) begin
                    w_stage_nxt = STAGE_FETCH;
                end
            end
            STAGE_FETCH: begin
                if (mem_ready) begin
                    w_instr_nxt = instr_in;
                    w_stage_nxt = STAGE_MEMORY_READ;
                end
            end
            STAGE_MEMORY_READ: begin
                if (mem_ready) begin
                    w_stage_nxt = STAGE_REGISTER_UPDATE;
                end
            end
            STAGE_REGISTER_UPDATE: begin
                w_stage_nxt = STAGE_MEMORY_WRITE;
            end
            STAGE_MEMORY_WRITE: begin
                if (mem_ready) begin
                    w_stage_nxt = STAGE_PC_UPDATE;
                end
            end
            STAGE_PC_UPDATE: begin
                w_pc_nxt      = pc_load ? pc_target : r_pc + 32'd4;
                w_retired_nxt = r_retired + 32'd1;
                if (r_halt_pending || halt_req) begin
                    w_stage_nxt        = STAGE_HALTED;
                    w_halt_pending_nxt = 1'b0;
                end else begin
                    w_stage_nxt = STAGE_FETCH;
                end
            end
            STAGE_HALTED: begin
                // A halt_req arriving with run re-arms the halt so the
                // resumed instruction stops again at its PC_UPDATE.
                if (run) begin
                    w_stage_nxt        = STAGE_FETCH;
                    w_bus_error_nxt    = 1'b0;
                    w_halt_pending_nxt = halt_req;
                end
            end
            default: begin
                w_stage_nxt = STAGE_IDLE;
            end
        endcase

        // A stalled memory stage that hits the limit abandons the
        // instruction; mem_ready in that same cycle has already won above.
        if (w_timeout) begin
            w_stage_nxt        = STAGE_HALTED;
            w_bus_error_nxt    = 1'b1;
            w_halt_pending_nxt = 1'b0;
        end
    end

    assign stage     = r_stage;
    assign mem_req   = is_mem_stage(r_stage);
    assign mem_we    = (r_stage == STAGE_MEMORY_WRITE);
    assign pc        = r_pc;
    assign instr     = r_instr;
    assign retired   = r_retired;
    assign bus_error = r_bus_error;

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage_sequencer
//  Description : Randomised self-checking bench for stage_sequencer. The
//                driver plans each instruction (wait delays, timeouts, halts,
//                branches), derives the expected per-cycle state from that
//                plan and queues it; a monitor pops and compares every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stage_sequencer;

    localparam logic [31:0] c_reset_pc = 32'h0000_0040;
    localparam int          T          = 4;

    logic        clk;
    logic        rst;
    logic        run;
    logic        halt_req;
    logic        mem_ready;
    logic [31:0] instr_in;
    logic        pc_load;
    logic [31:0] pc_target;
    logic [2:0]  stage;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] retired;
    logic        bus_error;

    stage_sequencer #(
        .RESET_PC    (c_reset_pc),
        .MEM_TIMEOUT (T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .halt_req  (halt_req),
        .mem_ready (mem_ready),
        .instr_in  (instr_in),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .stage     (stage),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .pc        (pc),
        .instr     (instr),
        .retired   (retired),
        .bus_error (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  stage;
        logic [31:0] pc;
        logic [31:0] retired;
        logic [31:0] instr;
        logic        berr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    // Reference state of the architectural registers.
    logic [31:0] pc_m, ret_m, instr_m;
    logic        berr_m, pend_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard: got empty queue required a record (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("stage",     {29'd0, stage},     {29'd0, e.stage});
                chk("pc",        pc,                 e.pc);
                chk("retired",   retired,            e.retired);
                chk("instr",     instr,              e.instr);
                chk("bus_error", {31'd0, bus_error}, {31'd0, e.berr});
                chk("mem_req",   {31'd0, mem_req},
                    {31'd0, (e.stage == 3'd0 || e.stage == 3'd1 || e.stage == 3'd3)});
                chk("mem_we",    {31'd0, mem_we},    {31'd0, (e.stage == 3'd3)});
            end
        end
    end

    task automatic push(input logic [2:0] st);
        exp_t r;
        r.stage   = st;
        r.pc      = pc_m;
        r.retired = ret_m;
        r.instr   = instr_m;
        r.berr    = berr_m;
        sb.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs that the current stage must ignore get random values.
    task automatic noise();
        run       = 1'($urandom);
        mem_ready = 1'($urandom);
        instr_in  = $urandom;
        pc_load   = 1'($urandom);
        pc_target = $urandom;
        halt_req  = 1'b0;
    endtask

    function automatic int pick_delay();
        return ($urandom_range(0, 11) == 0) ? 99 : int'($urandom_range(0, T - 1));
    endfunction

    // One memory stage: ready after d wait cycles, or a timeout if d >= T.
    task automatic mem_phase(input logic [2:0] st, input int d, output bit to);
        to = 1'b0;
        for (int k = 0; k < T; k++) begin
            noise();
            mem_ready = (k == d);
            halt_req  = ($urandom_range(0, 15) == 0);
            push(st);
            if (halt_req) pend_m = 1'b1;
            if (mem_ready) begin
                if (st == 3'd0) instr_m = instr_in;
                step();
                return;
            end
            if (k == T - 1) begin
                berr_m = 1'b1;
                pend_m = 1'b0;
                to     = 1'b1;
                step();
                return;
            end
            step();
        end
    endtask

    task automatic halted_phase();
        int n;
        n = int'($urandom_range(0, 3));
        for (int k = 0; k < n; k++) begin
            noise();
            run      = 1'b0;
            halt_req = 1'($urandom);
            push(3'd6);
            step();
        end
        noise();
        run      = 1'b1;
        halt_req = ($urandom_range(0, 3) == 0);
        push(3'd6);
        pend_m = halt_req;
        berr_m = 1'b0;
        step();
    endtask

    task automatic do_instr();
        bit   to;
        logic halted;
        mem_phase(3'd0, pick_delay(), to);
        if (to) begin halted_phase(); return; end
        mem_phase(3'd1, pick_delay(), to);
        if (to) begin halted_phase(); return; end
        noise();
        halt_req = ($urandom_range(0, 15) == 0);
        push(3'd2);
        if (halt_req) pend_m = 1'b1;
        step();
        mem_phase(3'd3, pick_delay(), to);
        if (to) begin halted_phase(); return; end
        noise();
        halt_req = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 3) == 0) pc_target = 32'hFFFF_FFFC;
        push(3'd4);
        pc_m   = pc_load ? pc_target : pc_m + 32'd4;
        ret_m  = ret_m + 32'd1;
        halted = pend_m | halt_req;
        pend_m = 1'b0;
        step();
        if (halted) halted_phase();
    endtask

    task automatic model_reset();
        pc_m    = c_reset_pc;
        ret_m   = 32'd0;
        instr_m = 32'd0;
        berr_m  = 1'b0;
        pend_m  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit to;
        rst = 1'b1; run = 1'b0; halt_req = 1'b0; mem_ready = 1'b1;
        instr_in = 32'hFFFF_FFFF; pc_load = 1'b0; pc_target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stage",   {29'd0, stage},     32'd5);
        chk("rst_pc",      pc,                 c_reset_pc);
        chk("rst_instr",   instr,              32'd0);
        chk("rst_retired", retired,            32'd0);
        chk("rst_mem_req", {31'd0, mem_req},   32'd0);
        chk("rst_berr",    {31'd0, bus_error}, 32'd0);

        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            noise(); run = 1'b0; halt_req = 1'b1;
            push(3'd5);
            step();
        end
        // halt_req alongside run in IDLE must not arm a halt.
        noise(); run = 1'b1; halt_req = 1'b1;
        push(3'd5);
        step();

        for (int i = 0; i < 150; i++) do_instr();

        // Asynchronous reset while a write is in progress.
        mem_phase(3'd0, 0, to);
        mem_phase(3'd1, 0, to);
        noise(); halt_req = 1'b0;
        push(3'd2);
        step();
        mon_en = 1'b0;
        run = 1'b1; halt_req = 1'b0; mem_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_stage",   {29'd0, stage},   32'd5);
        chk("async_rst_pc",      pc,               c_reset_pc);
        chk("async_rst_retired", retired,          32'd0);
        chk("async_rst_mem_we",  {31'd0, mem_we},  32'd0);
        step();
        #1 rst = 1'b0;
        model_reset();
        mon_en = 1'b1;
        push(3'd5);
        step();
        for (int i = 0; i < 3; i++) do_instr();
        mon_en = 1'b0;

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
